// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: ALU op codes, B-operand
// select codes and the ID/EX stage register layout.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;

    // B operand source
    localparam logic [1:0] BSEL_RT    = 2'd0;
    localparam logic [1:0] BSEL_IMM   = 2'd1;
    localparam logic [1:0] BSEL_SHAMT = 2'd2;
    localparam logic [1:0] BSEL_RS    = 2'd3;

    // ID/EX register contents; all-zero is a NOP (ADD, no write-back)
    typedef struct packed {
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] rt;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc8;
        logic [RW-1:0]   rs_addr;
        logic [RW-1:0]   rt_addr;
        logic [RW-1:0]   shamt;
        logic [RW-1:0]   wr_addr;
        logic [2:0]      alu_op;
        logic            a_sel;
        logic [1:0]      b_sel;
        logic            wr_en;
        logic            is_load;
    } idex_t;

    // Register-file bypass at capture time: the regfile does not write through,
    // so a same-cycle WB write to the source register must be taken here.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic [RW-1:0]   addr,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_wr_en,
        input logic [RW-1:0]   wb_wr_addr,
        input logic [XLEN-1:0] wb_data
    );
        if (wb_wr_en && (wb_wr_addr == addr) && (addr != '0))
            return wb_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// EX-stage operand forwarding for one source register. The MEM producer is
// younger than WB and wins; a MEM producer whose value is not ready yet
// (load) raises miss and falls back to the queued value.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [RW-1:0]   addr,
    input  logic [XLEN-1:0] q_val,
    input  logic            mem_wr_en,
    input  logic [RW-1:0]   mem_wr_addr,
    input  logic            mem_fwd_ok,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_wr_en,
    input  logic [RW-1:0]   wb_wr_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_val,
    output logic            miss
);

    // Priority select: $0 never forwards, then MEM, then WB, then queued value
    always_comb begin
        fwd_val = q_val;
        miss    = 1'b0;
        if (addr == '0) begin
            fwd_val = q_val;
        end else if (mem_wr_en && (mem_wr_addr == addr)) begin
            if (mem_fwd_ok) fwd_val = mem_fwd_data;
            else            miss    = 1'b1;
        end else if (wb_wr_en && (wb_wr_addr == addr)) begin
            fwd_val = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage rs/rt forwarding. Drives the ALU
// operands directly and carries store data and write-back control to EX/MEM.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            bubble,
    input  logic [RW-1:0]   id_rs_addr,
    input  logic [RW-1:0]   id_rt_addr,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [XLEN-1:0] id_imm32,
    input  logic [RW-1:0]   id_shamt,
    input  logic [2:0]      id_alu_op,
    input  logic            id_a_sel,
    input  logic [1:0]      id_b_sel,
    input  logic            id_wr_en,
    input  logic [RW-1:0]   id_wr_addr,
    input  logic            id_is_load,
    input  logic [XLEN-1:0] id_pc8,
    input  logic            mem_wr_en,
    input  logic [RW-1:0]   mem_wr_addr,
    input  logic            mem_fwd_ok,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_wr_en,
    input  logic [RW-1:0]   wb_wr_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_wr_en,
    output logic [RW-1:0]   ex_wr_addr,
    output logic            ex_is_load,
    output logic [XLEN-1:0] ex_pc8,
    output logic [RW-1:0]   ex_rs_addr,
    output logic [RW-1:0]   ex_rt_addr,
    output logic            hazard_miss
);

    idex_t           st;
    idex_t           nxt;
    logic [XLEN-1:0] fwd_rs;
    logic [XLEN-1:0] fwd_rt;
    logic            miss_rs;
    logic            miss_rt;

    // Assemble the next stage contents from ID, with regfile bypass on rs/rt
    always_comb begin
        nxt         = '0;
        nxt.rs      = wb_bypass(id_rs_addr, id_rs_data, wb_wr_en, wb_wr_addr, wb_data);
        nxt.rt      = wb_bypass(id_rt_addr, id_rt_data, wb_wr_en, wb_wr_addr, wb_data);
        nxt.imm     = id_imm32;
        nxt.pc8     = id_pc8;
        nxt.rs_addr = id_rs_addr;
        nxt.rt_addr = id_rt_addr;
        nxt.shamt   = id_shamt;
        nxt.wr_addr = id_wr_addr;
        nxt.alu_op  = id_alu_op;
        nxt.a_sel   = id_a_sel;
        nxt.b_sel   = id_b_sel;
        nxt.wr_en   = id_wr_en;
        nxt.is_load = id_is_load;
    end

    // Stage register: reset > hold > bubble > load. Hold refreshes the operands
    // with their forwarded values so a producer retiring mid-hold is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= '0;
        end else if (hold) begin
            st.rs <= fwd_rs;
            st.rt <= fwd_rt;
        end else if (bubble) begin
            st <= '0;
        end else begin
            st <= nxt;
        end
    end

    fwd_mux u_fwd_rs (
        .addr         (st.rs_addr),
        .q_val        (st.rs),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_fwd_ok   (mem_fwd_ok),
        .mem_fwd_data (mem_fwd_data),
        .wb_wr_en     (wb_wr_en),
        .wb_wr_addr   (wb_wr_addr),
        .wb_data      (wb_data),
        .fwd_val      (fwd_rs),
        .miss         (miss_rs)
    );

    fwd_mux u_fwd_rt (
        .addr         (st.rt_addr),
        .q_val        (st.rt),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_fwd_ok   (mem_fwd_ok),
        .mem_fwd_data (mem_fwd_data),
        .wb_wr_en     (wb_wr_en),
        .wb_wr_addr   (wb_wr_addr),
        .wb_data      (wb_data),
        .fwd_val      (fwd_rt),
        .miss         (miss_rt)
    );

    // ALU operand selection from forwarded values
    always_comb begin
        alu_a = st.a_sel ? fwd_rt : fwd_rs;
        case (st.b_sel)
            BSEL_RT:    alu_b = fwd_rt;
            BSEL_IMM:   alu_b = st.imm;
            BSEL_SHAMT: alu_b = {{(XLEN-RW){1'b0}}, st.shamt};
            default:    alu_b = fwd_rs;
        endcase
    end

    assign alu_op        = st.alu_op;
    assign ex_store_data = fwd_rt;
    assign ex_wr_en      = st.wr_en;
    assign ex_wr_addr    = st.wr_addr;
    assign ex_is_load    = st.is_load;
    assign ex_pc8        = st.pc8;
    assign ex_rs_addr    = st.rs_addr;
    assign ex_rt_addr    = st.rt_addr;
    assign hazard_miss   = miss_rs | miss_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes hand-computed expected
// outputs into a queue, a monitor pops and compares on the falling edge.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset, hold, bubble;
    logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wr_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm32, id_pc8;
    logic [2:0]  id_alu_op;
    logic        id_a_sel, id_wr_en, id_is_load;
    logic [1:0]  id_b_sel;
    logic        mem_wr_en, mem_fwd_ok, wb_wr_en;
    logic [4:0]  mem_wr_addr, wb_wr_addr;
    logic [31:0] mem_fwd_data, wb_data;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc8;
    logic [2:0]  alu_op;
    logic        ex_wr_en, ex_is_load, hazard_miss;
    logic [4:0]  ex_wr_addr, ex_rs_addr, ex_rt_addr;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .hold(hold), .bubble(bubble),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm32(id_imm32), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_is_load(id_is_load), .id_pc8(id_pc8),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_fwd_ok(mem_fwd_ok), .mem_fwd_data(mem_fwd_data),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_wr_en(ex_wr_en),
        .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load), .ex_pc8(ex_pc8),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .hazard_miss(hazard_miss)
    );

    typedef struct {
        string       name;
        logic [31:0] a, b, st;
        logic [2:0]  op;
        logic        we;
        logic [4:0]  wa;
        logic        hz;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic set_id(input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] sh,
                          input logic [2:0] op, input logic asel,
                          input logic [1:0] bsel, input logic we,
                          input logic [4:0] wa);
        id_rs_addr = rs;  id_rs_data = rsd;
        id_rt_addr = rt;  id_rt_data = rtd;
        id_imm32 = imm;   id_shamt = sh;   id_alu_op = op;
        id_a_sel = asel;  id_b_sel = bsel;
        id_wr_en = we;    id_wr_addr = wa; id_is_load = 1'b0; id_pc8 = 32'h0;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Push an expectation and wait (bounded) for the monitor to consume it
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] st,
                       input logic we, input logic [4:0] wa, input logic hz);
        exp_t e;
        e.name = nm; e.a = a; e.b = b; e.op = op; e.st = st;
        e.we = we; e.wa = wa; e.hz = hz;
        q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s timeout: queue depth %0d required 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    n_chk++; if (alu_a !== e.a) begin n_err++; $display("FAIL %s alu_a: got %h want %h", e.name, alu_a, e.a); end
                    n_chk++; if (alu_b !== e.b) begin n_err++; $display("FAIL %s alu_b: got %h want %h", e.name, alu_b, e.b); end
                    n_chk++; if (alu_op !== e.op) begin n_err++; $display("FAIL %s alu_op: got %h want %h", e.name, alu_op, e.op); end
                    n_chk++; if (ex_store_data !== e.st) begin n_err++; $display("FAIL %s store: got %h want %h", e.name, ex_store_data, e.st); end
                    n_chk++; if (ex_wr_en !== e.we) begin n_err++; $display("FAIL %s wr_en: got %b want %b", e.name, ex_wr_en, e.we); end
                    n_chk++; if (ex_wr_addr !== e.wa) begin n_err++; $display("FAIL %s wr_addr: got %0d want %0d", e.name, ex_wr_addr, e.wa); end
                    n_chk++; if (hazard_miss !== e.hz) begin n_err++; $display("FAIL %s hazard_miss: got %b want %b", e.name, hazard_miss, e.hz); end
                end
            end
        join_none

        // Reset with hold asserted: reset wins
        reset = 1'b1; hold = 1'b1; bubble = 1'b0;
        mem_wr_en = 1'b0; mem_wr_addr = 5'd0; mem_fwd_ok = 1'b0; mem_fwd_data = 32'h0;
        wb_wr_en = 1'b0; wb_wr_addr = 5'd0; wb_data = 32'h0;
        set_id(5'd8, 32'h55, 5'd9, 32'h66, 32'h77, 5'd3, ALU_XOR, 1'b0, BSEL_IMM, 1'b1, 5'd10);
        edge1();
        reset = 1'b0; hold = 1'b0;
        chk("reset", 32'h0, 32'h0, ALU_ADD, 32'h0, 1'b0, 5'd0, 1'b0);

        // Plain load: rs=$8=5, imm=3
        set_id(5'd8, 32'd5, 5'd9, 32'h11, 32'd3, 5'd0, ALU_ADD, 1'b0, BSEL_IMM, 1'b1, 5'd10);
        edge1();
        chk("load", 32'd5, 32'd3, ALU_ADD, 32'h11, 1'b1, 5'd10, 1'b0);

        // MEM and WB both write $8: MEM wins
        edge1();
        mem_wr_en = 1'b1; mem_wr_addr = 5'd8; mem_fwd_ok = 1'b1; mem_fwd_data = 32'h100;
        wb_wr_en = 1'b1; wb_wr_addr = 5'd8; wb_data = 32'h200;
        chk("mem_over_wb", 32'h100, 32'd3, ALU_ADD, 32'h11, 1'b1, 5'd10, 1'b0);

        // Reload captures WB $8 via regfile bypass; drop MEM match
        edge1();
        mem_wr_en = 1'b0;
        chk("wb_only", 32'h200, 32'd3, ALU_ADD, 32'h11, 1'b1, 5'd10, 1'b0);

        // WB writes $0 = 0xFFFF: never forwarded
        set_id(5'd0, 32'h0, 5'd9, 32'h11, 32'h0, 5'd0, ALU_ADD, 1'b0, BSEL_RS, 1'b0, 5'd0);
        wb_wr_en = 1'b1; wb_wr_addr = 5'd0; wb_data = 32'hFFFF;
        edge1();
        chk("reg0", 32'h0, 32'h0, ALU_ADD, 32'h11, 1'b0, 5'd0, 1'b0);

        // Hold: $9 = 7 from MEM, then from WB, then retired
        wb_wr_en = 1'b0;
        set_id(5'd9, 32'd1, 5'd3, 32'd2, 32'h0, 5'd0, ALU_SUB, 1'b0, BSEL_RT, 1'b1, 5'd12);
        mem_wr_en = 1'b1; mem_wr_addr = 5'd9; mem_fwd_ok = 1'b1; mem_fwd_data = 32'd7;
        edge1();
        hold = 1'b1;
        set_id(5'd9, 32'h999, 5'd3, 32'h333, 32'hBAD, 5'd1, ALU_XOR, 1'b1, BSEL_IMM, 1'b0, 5'd31);
        chk("hold0", 32'd7, 32'd2, ALU_SUB, 32'd2, 1'b1, 5'd12, 1'b0);
        edge1();
        mem_wr_en = 1'b0;
        wb_wr_en = 1'b1; wb_wr_addr = 5'd9; wb_data = 32'd7;
        bubble = 1'b1;
        chk("hold1", 32'd7, 32'd2, ALU_SUB, 32'd2, 1'b1, 5'd12, 1'b0);
        edge1();
        wb_wr_en = 1'b0;
        chk("hold_bubble", 32'd7, 32'd2, ALU_SUB, 32'd2, 1'b1, 5'd12, 1'b0);

        // Load-use: MEM load to $4 not ready -> hazard_miss, then bubble
        hold = 1'b0; bubble = 1'b0;
        set_id(5'd4, 32'h44, 5'd0, 32'h0, 32'd5, 5'd0, ALU_OR, 1'b0, BSEL_IMM, 1'b1, 5'd13);
        edge1();
        mem_wr_en = 1'b1; mem_wr_addr = 5'd4; mem_fwd_ok = 1'b0; mem_fwd_data = 32'hDEAD;
        bubble = 1'b1;
        chk("miss", 32'h44, 32'd5, ALU_OR, 32'h0, 1'b1, 5'd13, 1'b1);
        edge1();
        bubble = 1'b0; mem_wr_en = 1'b0;
        chk("bubble", 32'h0, 32'h0, ALU_ADD, 32'h0, 1'b0, 5'd0, 1'b0);

        // Reset mid-hold clears the stage
        set_id(5'd5, 32'd9, 5'd0, 32'h0, 32'h10, 5'd0, ALU_XOR, 1'b0, BSEL_IMM, 1'b1, 5'd14);
        edge1();
        hold = 1'b1; reset = 1'b1;
        chk("pre_reset", 32'd9, 32'h10, ALU_XOR, 32'h0, 1'b1, 5'd14, 1'b0);
        edge1();
        reset = 1'b0; hold = 1'b0;
        chk("reset_hold", 32'h0, 32'h0, ALU_ADD, 32'h0, 1'b0, 5'd0, 1'b0);

        // Shamt path, a_sel=rt, rt captured via WB bypass
        set_id(5'd0, 32'h0, 5'd6, 32'hABCD, 32'hFFFF_FFFF, 5'd31, ALU_SLL, 1'b1, BSEL_SHAMT, 1'b1, 5'd15);
        wb_wr_en = 1'b1; wb_wr_addr = 5'd6; wb_data = 32'h1234;
        edge1();
        wb_wr_en = 1'b0;
        chk("shamt", 32'h1234, 32'd31, ALU_SLL, 32'h1234, 1'b1, 5'd15, 1'b0);

        // rt forwarding into B and store data: MEM over WB
        set_id(5'd0, 32'h0, 5'd7, 32'd1, 32'h0, 5'd0, ALU_AND, 1'b0, BSEL_RT, 1'b1, 5'd16);
        edge1();
        mem_wr_en = 1'b1; mem_wr_addr = 5'd7; mem_fwd_ok = 1'b1; mem_fwd_data = 32'hCAFE;
        wb_wr_en = 1'b1; wb_wr_addr = 5'd7; wb_data = 32'hBEEF;
        chk("rt_fwd", 32'h0, 32'hCAFE, ALU_AND, 32'hCAFE, 1'b1, 5'd16, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with EX-stage operand forwarding for the five-stage MIPS core. It captures decoded operands and control from ID and resolves rs/rt data hazards against the EX/MEM and MEM/WB stages. It then drives the ALU's `A`, `B` and `ALUOp` inputs directly. It also carries the forwarded store data and write-back control toward EX/MEM.

## Interface
Parameters:
- none (datapath fixed at 32 bits, register addresses at 5 bits)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `hold`  in  1  freeze stage contents (EX busy)
- `bubble`  in  1  load a NOP instead of ID contents (load-use stall)
- `id_rs_addr`, `id_rt_addr`  in  5 each  source register numbers
- `id_rs_data`, `id_rt_data`  in  32 each  register-file read data
- `id_imm32`  in  32  extended immediate
- `id_shamt`  in  5  shift amount field
- `id_alu_op`  in  3  ALU operation code
- `id_a_sel`  in  1  A source: 0 = rs, 1 = rt
- `id_b_sel`  in  2  B source: 0 = rt, 1 = imm32, 2 = zero-extended shamt, 3 = rs
- `id_wr_en`, `id_wr_addr`  in  1, 5  destination register
- `id_is_load`  in  1  instruction is a load
- `id_pc8`  in  32  PC+8 (link value)
- `mem_wr_en`, `mem_wr_addr`, `mem_fwd_ok`, `mem_fwd_data`  in  1, 5, 1, 32  EX/MEM producer; `mem_fwd_ok` = 0 when the value is not yet available (load)
- `wb_wr_en`, `wb_wr_addr`, `wb_data`  in  1, 5, 32  MEM/WB producer
- `alu_a`, `alu_b`  out  32 each  ALU operands
- `alu_op`  out  3  ALU operation
- `ex_store_data`  out  32  forwarded rt
- `ex_wr_en`, `ex_wr_addr`, `ex_is_load`, `ex_pc8`  out  registered control pass-through
- `ex_rs_addr`, `ex_rt_addr`  out  5 each  for the hazard unit
- `hazard_miss`  out  1  combinational error flag

## Operation
- Update priority at each edge: `reset` > `hold` > `bubble` > normal load.
- **Reset / bubble:** all registered fields are cleared to 0. This gives `alu_op` = ADD (000), `wr_en` = 0, `is_load` = 0, addresses = 0 and data = 0. All outputs therefore read 0 after reset.
- **Normal load:** every `id_*` field is captured.
  - `rs_q` takes `wb_data` when `wb_wr_en` is set, `wb_wr_addr == id_rs_addr` and `id_rs_addr != 0`. Otherwise it takes `id_rs_data`.
  - `rt_q` follows the same rule.
  - This covers the register file, which does not write-through in the same cycle.
- **Hold:** control fields are kept. `rs_q` and `rt_q` are reloaded with their current forwarded values (`fwd_rs`, `fwd_rt`), so a WB producer that retires during the hold is not lost.
- **Forwarding** is combinational, applied to `fwd_rs` and `fwd_rt` (shown here for rs):
  - If `ex_rs_addr == 0`: use `rs_q`.
  - Else if `mem_wr_en` is set and `mem_wr_addr == ex_rs_addr`:
    - use `mem_fwd_data` if `mem_fwd_ok` is set;
    - otherwise use `rs_q` and assert `hazard_miss`.
  - Else if `wb_wr_en` is set and `wb_wr_addr == ex_rs_addr`: use `wb_data`.
  - Else: use `rs_q`.
- **Operand selection:**
  - `alu_a` = `a_sel` ? `fwd_rt` : `fwd_rs`.
  - `alu_b` is selected by `b_sel`: `fwd_rt`, `imm_q`, `{27'b0, shamt_q}` or `fwd_rs`.
  - `ex_store_data` = `fwd_rt`.
- `hazard_miss` must never assert in a correct pipeline. The hazard unit guarantees this by asserting `bubble`.

## Timing
- Latency: ID inputs appear on the `ex_*` and ALU outputs one cycle after the capturing edge.
- Forwarding adds no cycles: a change on the `mem_*` or `wb_*` inputs reaches `alu_a`, `alu_b` and `ex_store_data` in the same cycle.
- `hold` and `bubble` asserted together: `hold` wins and `bubble` is ignored.
- `reset` asserted mid-hold: the stage is cleared at that edge.
- A MEM match and a WB match on the same register: MEM wins (younger producer).

## Structure
- Shared package `mips_pkg`:
  - ALU op constants: ADD 000, SUB 001, OR 010, AND 011, XOR 100, SLL 101, SRL 110.
  - `b_sel` constants: `BSEL_RT`, `BSEL_IMM`, `BSEL_SHAMT`, `BSEL_RS`.
- Sub-module `fwd_mux`:
  - inputs: register address, queued value, MEM/WB producer ports;
  - outputs: forwarded value, miss flag;
  - instantiated twice (rs, rt).

## Test plan
- Reset with `hold` = 1 → all outputs are 0 the next cycle and `alu_op` = 000.
- Load rs=$8 (`id_rs_data` = 5), imm = 3, `b_sel` = 1, op = ADD, no producers → `alu_a` = 5, `alu_b` = 3.
- EX/MEM writes $8 = 0x100 and MEM/WB writes $8 = 0x200 in the same cycle → `alu_a` = 0x100. Drop the MEM match → `alu_a` = 0x200.
- `wb_wr_addr` = 0, `wb_data` = 0xFFFF, EX reads $0 → `alu_a` = 0 and no forward taken.
- `hold` for 2 cycles while a WB producer of $9 = 7 retires after the first cycle → `alu_a` stays 7 throughout.
- EX/MEM load to $4 (`mem_fwd_ok` = 0) while EX reads $4 → `hazard_miss` = 1. Next edge with `bubble` → `ex_wr_en` = 0 and `alu_op` = 000.
